// File: rtl/calc_stack_n.sv
// calc_stack_n
// Operand stack for the RPN calculator datapath. The two topmost entries
// are held in registers so an ALU sees both operands combinationally.
// Deeper entries spill into an inferred single-port block RAM with a
// synchronous write and a one-cycle registered read.
//
// Ports
//   clk, reset   clock; synchronous active-high reset
//   cmd          opcode: 0 NOP, 1 PUSH, 2 POP, 3 REPLACE, 4 REDUCE,
//                5 DUP, 6 SWAP, 7 CLEAR
//   cmd_vld      command strobe
//   in_num       operand for PUSH, REPLACE and REDUCE
//   ready        high in IDLE, low during the single FILL cycle
//   top, next    entries size-1 and size-2 (zero when absent)
//   size         current entry count, 0..DEPTH
//   error        outcome of the last accepted non-NOP command
//   dbg_state_o  FSM state (0 IDLE, 1 FILL)
//
// Handshake: a command is accepted on a rising clock edge where
// cmd_vld=1 and ready=1. While ready=0, cmd_vld is ignored and nothing is
// queued; the issuer must hold or re-present the command once ready
// returns. top, size and error update on the accepting edge; next becomes
// valid one cycle later when a RAM refill is needed.
module calc_stack_n #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            cmd,
  input  logic                  cmd_vld,
  input  logic [WIDTH-1:0]      in_num,
  output logic                  ready,
  output logic [WIDTH-1:0]      top,
  output logic [WIDTH-1:0]      next,
  output logic [DEPTH_LOG2:0]   size,
  output logic                  error,
  output logic                  dbg_state_o
);

  localparam int RAM_DEPTH = (1 << DEPTH_LOG2) - 2;

  localparam logic [DEPTH_LOG2:0] SZ_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] SZ_0    = '0;
  localparam logic [DEPTH_LOG2:0] SZ_1    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0] SZ_2    = (DEPTH_LOG2+1)'(2);
  localparam logic [DEPTH_LOG2:0] SZ_3    = (DEPTH_LOG2+1)'(3);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_REPLACE = 3'd3;
  localparam logic [2:0] OP_REDUCE  = 3'd4;
  localparam logic [2:0] OP_DUP     = 3'd5;
  localparam logic [2:0] OP_SWAP    = 3'd6;
  localparam logic [2:0] OP_CLEAR   = 3'd7;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      top_q, top_d;
  logic [WIDTH-1:0]      next_q, next_d;
  logic [DEPTH_LOG2:0]   size_q, size_d;
  logic                  error_q, error_d;

  logic                  ram_we;
  logic                  ram_re;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [WIDTH-1:0]      ram_rd_q;
  logic [DEPTH_LOG2:0]   sz_m2;
  logic [DEPTH_LOG2:0]   sz_m3;

  logic [WIDTH-1:0]      mem [RAM_DEPTH];

  // Spill RAM: one port, write-or-read per cycle, registered read data.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= next_q;
    end
    if (ram_re) begin
      ram_rd_q <= mem[ram_addr];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      top_q   <= '0;
      next_q  <= '0;
      size_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      top_q   <= top_d;
      next_q  <= next_d;
      size_q  <= size_d;
      error_q <= error_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    top_d    = top_q;
    next_d   = next_q;
    size_d   = size_q;
    error_d  = error_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = '0;
    // RAM slot of the entry below next (write) and the new next (read).
    // Only sliced into an address when the matching size guard holds.
    sz_m2    = size_q - SZ_2;
    sz_m3    = size_q - SZ_3;

    if (state_q == S_FILL) begin
      next_d  = ram_rd_q;
      state_d = S_IDLE;
    end else if (cmd_vld) begin
      case (cmd)
        OP_PUSH, OP_DUP: begin
          if (size_q == SZ_FULL || (cmd == OP_DUP && size_q == SZ_0)) begin
            error_d = 1'b1;
          end else begin
            if (size_q >= SZ_2) begin
              ram_we   = 1'b1;
              ram_addr = sz_m2[DEPTH_LOG2-1:0];
            end
            next_d  = top_q;
            top_d   = (cmd == OP_DUP) ? top_q : in_num;
            size_d  = size_q + SZ_1;
            error_d = 1'b0;
          end
        end
        OP_POP: begin
          if (size_q == SZ_0) begin
            error_d = 1'b1;
          end else begin
            // With size 1, next_q is already zero, so top clears naturally.
            top_d   = next_q;
            size_d  = size_q - SZ_1;
            error_d = 1'b0;
            if (size_q >= SZ_3) begin
              ram_re   = 1'b1;
              ram_addr = sz_m3[DEPTH_LOG2-1:0];
              state_d  = S_FILL;
            end else begin
              next_d = '0;
            end
          end
        end
        OP_REDUCE: begin
          if (size_q < SZ_2) begin
            error_d = 1'b1;
          end else begin
            top_d   = in_num;
            size_d  = size_q - SZ_1;
            error_d = 1'b0;
            if (size_q >= SZ_3) begin
              ram_re   = 1'b1;
              ram_addr = sz_m3[DEPTH_LOG2-1:0];
              state_d  = S_FILL;
            end else begin
              next_d = '0;
            end
          end
        end
        OP_REPLACE: begin
          if (size_q == SZ_0) begin
            error_d = 1'b1;
          end else begin
            top_d   = in_num;
            error_d = 1'b0;
          end
        end
        OP_SWAP: begin
          if (size_q < SZ_2) begin
            error_d = 1'b1;
          end else begin
            top_d   = next_q;
            next_d  = top_q;
            error_d = 1'b0;
          end
        end
        OP_CLEAR: begin
          top_d   = '0;
          next_d  = '0;
          size_d  = '0;
          error_d = 1'b0;
        end
        default: begin
          // NOP: nothing changes, error is kept.
        end
      endcase
    end
  end

  // Outputs
  always_comb begin
    ready       = (state_q == S_IDLE);
    dbg_state_o = state_q;
    top         = top_q;
    next        = next_q;
    size        = size_q;
    error       = error_q;
  end

endmodule
